// File: rtl/a_unit_pkg.sv
// Shared types and constants for the A-unit issue scheduler.
// Holds opcode encodings, default unit latencies, widths and the
// write-back timeline slot payload.
package a_unit_pkg;

   localparam int unsigned NREG        = 8;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned OP_W        = 7;
   localparam int unsigned LAT_W       = 3;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned DEF_ADD_LAT = 2;
   localparam int unsigned DEF_MUL_LAT = 6;

   localparam logic [OP_W-1:0] OP_AADD = 7'o030;
   localparam logic [OP_W-1:0] OP_ASUB = 7'o031;
   localparam logic [OP_W-1:0] OP_AMUL = 7'o032;

   // One pending write-back: destination index and result source (1 = multiply).
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic             sel;
   } wb_slot_t;

endpackage

// File: rtl/a_wb_timeline.sv
// Write-back timeline: DEPTH-slot shift register of pending A writes.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_ins_en      insert i_ins_slot at depth i_ins_depth (after this cycle's shift)
//   i_qry_depth   depth to test for availability after the shift
//   o_qry_free_c  combinational: slot i_qry_depth will be free after the shift
//   o_head        slot 1 (registered), drives the shared write path
module a_wb_timeline
   import a_unit_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_MUL_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ins_en,
   input  logic [LAT_W-1:0] i_ins_depth,
   input  wb_slot_t         i_ins_slot,
   input  logic [LAT_W-1:0] i_qry_depth,
   output logic             o_qry_free_c,
   output wb_slot_t         o_head
);

   wb_slot_t [DEPTH:1] r_slot;
   wb_slot_t [DEPTH:1] w_nxt;

   // Shift toward slot 1, then drop the new entry at its depth.
   always_comb begin
      w_nxt        = '0;
      for (int unsigned d = 1; d < DEPTH; d++) begin
         w_nxt[d] = r_slot[d+1];
      end
      for (int unsigned d = 1; d <= DEPTH; d++) begin
         if (i_ins_en && (i_ins_depth == LAT_W'(d))) begin
            w_nxt[d] = i_ins_slot;
         end
      end
   end

   // After the shift, slot d holds what slot d+1 holds now; the top slot is always empty.
   always_comb begin
      o_qry_free_c = 1'b1;
      for (int unsigned d = 1; d < DEPTH; d++) begin
         if (i_qry_depth == LAT_W'(d)) begin
            o_qry_free_c = ~r_slot[d+1].valid;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= '0;
      end else begin
         r_slot <= w_nxt;
      end
   end

   assign o_head = r_slot[1];

endmodule

// File: rtl/a_unit_sched.sv
// Issue scheduler for the address add (030/031) and multiply (032) units.
// Accepts one instruction per cycle, tracks A-register reservations until
// write-back and reserves a unique cycle on the shared A write path.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   i_issue_vld/o_issue_rdy  issue handshake (rdy is combinational)
//   i_instr, i_i, i_j, i_k   opcode, destination Ai, sources Aj/Ak
//   o_add_go/o_mul_go        launch pulses, o_fu_instr carries the opcode
//   o_wr_en/o_wr_idx/o_wr_sel  A register write-back
//   o_a_busy                 per-register reservation
//   o_inflight               launched, not yet written operations
module a_unit_sched
   import a_unit_pkg::*;
#(
   parameter int unsigned ADD_LAT = DEF_ADD_LAT,
   parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_issue_vld,
   output logic             o_issue_rdy,
   input  logic [OP_W-1:0]  i_instr,
   input  logic [IDX_W-1:0] i_i,
   input  logic [IDX_W-1:0] i_j,
   input  logic [IDX_W-1:0] i_k,
   output logic             o_add_go,
   output logic             o_mul_go,
   output logic [OP_W-1:0]  o_fu_instr,
   output logic             o_wr_en,
   output logic [IDX_W-1:0] o_wr_idx,
   output logic             o_wr_sel,
   output logic [NREG-1:0]  o_a_busy,
   output logic [CNT_W-1:0] o_inflight
);

   logic             w_is_add;
   logic             w_is_mul;
   logic [LAT_W-1:0] w_lat;
   logic             w_slot_free;
   logic             w_accept;
   wb_slot_t         w_ins_slot;
   wb_slot_t         w_head;
   logic [NREG-1:0]  w_busy_nxt;

   logic [NREG-1:0]  r_busy;
   logic [CNT_W-1:0] r_inflight;
   logic             r_add_go;
   logic             r_mul_go;
   logic [OP_W-1:0]  r_fu_instr;

   assign w_is_add = (i_instr == OP_AADD) || (i_instr == OP_ASUB);
   assign w_is_mul = (i_instr == OP_AMUL);
   assign w_lat    = w_is_mul ? LAT_W'(MUL_LAT) : LAT_W'(ADD_LAT);

   // Hazard checks: A0 as a source never stalls; a register writing back this cycle still blocks.
   assign o_issue_rdy = (w_is_add || w_is_mul)
                     && !r_busy[i_i]
                     && ((i_j == '0) || !r_busy[i_j])
                     && ((i_k == '0) || !r_busy[i_k])
                     && w_slot_free;

   assign w_accept   = i_issue_vld && o_issue_rdy;
   assign w_ins_slot = '{valid: 1'b1, idx: i_i, sel: w_is_mul};

   a_wb_timeline #(
      .DEPTH (MUL_LAT)
   ) u_timeline (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_ins_en     (w_accept),
      .i_ins_depth  (w_lat),
      .i_ins_slot   (w_ins_slot),
      .i_qry_depth  (w_lat),
      .o_qry_free_c (w_slot_free),
      .o_head       (w_head)
   );

   // Release on write-back, reserve on accept; accept never targets a busy register.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_head.valid) begin
         w_busy_nxt[w_head.idx] = 1'b0;
      end
      if (w_accept) begin
         w_busy_nxt[i_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_inflight <= '0;
         r_add_go   <= 1'b0;
         r_mul_go   <= 1'b0;
         r_fu_instr <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_head.valid);
         r_add_go   <= w_accept && w_is_add;
         r_mul_go   <= w_accept && w_is_mul;
         r_fu_instr <= w_accept ? i_instr : '0;
      end
   end

   assign o_add_go   = r_add_go;
   assign o_mul_go   = r_mul_go;
   assign o_fu_instr = r_fu_instr;
   assign o_wr_en    = w_head.valid;
   assign o_wr_idx   = w_head.idx;
   assign o_wr_sel   = w_head.sel;
   assign o_a_busy   = r_busy;
   assign o_inflight = r_inflight;

endmodule
